ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Shares one single-ported RAM bank (a RAM8-class array of `bit`/register cells: combinational read, write on `load` at the clock edge) between two requesters. Arbitration is round-robin with a bounded burst tenure. Selected address, data and load are steered to the RAM in the grant cycle, and read data is registered back to the winner one cycle later. Sits between the memory array and its two clients, for example the CPU data port and a DMA/loader port.

## Interface
- `DATA_W`, 16, RAM word width
- `ADDR_W`, 3, RAM address width (8 words)
- `MAX_BURST`, 4, maximum consecutive grants to one requester while the other waits; must be ≥1
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req0`, `req1`  in  1  access request, held until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  word address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  combinational; access performed this cycle
- `rdata0`, `rdata1`  out  DATA_W  registered read data, held until next read by that requester
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse, `rdataN` updated
- `ram_addr`  out  ADDR_W  to RAM address
- `ram_in`  out  DATA_W  to RAM data in
- `ram_load`  out  1  to RAM load
- `ram_out`  in  DATA_W  RAM combinational read data

## Operation
- State: `owner` FSM {IDLE, OWN0, OWN1}; `last` (1 bit, id of most recent grantee); `cnt` (width clog2(MAX_BURST+1)) = grants in current tenure, saturating at MAX_BURST.
- Grant decision each cycle, from registered state plus current `req`:
  - No requests: no grant. Next state IDLE, cnt=0, `last` unchanged.
  - Exactly one request: grant it. If it is the current owner, cnt++ (saturating); otherwise switch owner and set cnt=1.
  - Both requesting, state IDLE: grant `~last`, owner=`~last`, cnt=1.
  - Both requesting, state OWNx: if cnt < MAX_BURST, grant x and increment cnt. Otherwise grant the other, switch owner, set cnt=1.
  - `last` ← granted id on every grant.
- `gnt0` and `gnt1` are never both 1.
- Muxing: with `gntN`=1, `ram_addr`=`addrN`, `ram_in`=`wdataN`, `ram_load`=`weN`. With no grant, `ram_load`=0 and addr/in are driven from requester 0 (don't-care).
- Reads: on the edge ending a granted read, `rdataN` ← `ram_out` and `rvalidN`=1 for the following cycle.
- Writes: the RAM commits on the edge ending the grant cycle. No `rvalid` is produced.
- Requesters drop `req` after sampling `gnt` high, or keep it high for back-to-back accesses. Each cycle with `gnt` high is one complete access.

## Timing
- Grant latency: 0 cycles when uncontended (`gnt` in the same cycle as `req`).
- Read data latency: 1 cycle after `gnt`.
- Worst-case wait under contention: MAX_BURST cycles.
- Back-to-back: one access per cycle sustained. Alternating owners cost no bubble.
- Reset values: owner=IDLE, `last`=1 (requester 0 wins the first tie), cnt=0, `rdata0`/`rdata1`=0, `rvalid0`/`rvalid1`=0.
- While `reset`=1: `gnt0`/`gnt1`=0 and `ram_load`=0 combinationally, so no write reaches the RAM in a reset cycle. An access in flight when reset asserts is dropped, and its pending `rvalid` is cleared.
- Read and write to the same address from different requesters in consecutive cycles: the read returns the newly written value (write commits before the next cycle's combinational read).
- MAX_BURST=1: strict alternation under contention.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles with `req0`=`we0`=1. Required: no `gnt`, `ram_load`=0. After release, all rdata=0 and rvalid=0.
- Single write/read: `req0`, `we0`=1, addr 5, data 0xBEEF for 1 cycle, then a read of addr 5. Required: `gnt0` in both cycles, `rdata0`=0xBEEF with `rvalid0`=1 one cycle after the read grant.
- First tie: both request from IDLE after reset. Required: `gnt0` first.
- Sustained contention, MAX_BURST=4: both requesters hold `req` for 12 cycles. Required: grant pattern 0,0,0,0,1,1,1,1,0,0,0,0, never both granted.
- Handoff: owner 0 drops `req` mid-burst (after 2 grants) while `req1` is high. Required: `gnt1` the next cycle with cnt=1. An uncontended requester 1 then holds the grant beyond 4 cycles.
- Cross-requester coherence and reset mid-access: requester 1 writes 0x1234 to addr 2, then requester 0 reads addr 2 next cycle. Required: `rdata0`=0x1234. Assert `reset` during a requester-1 read grant. Required: `rvalid1` stays 0 and `rdata1` goes to 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter_if : requester and RAM-side signals of ram_port_arbiter
// Revision 1.0
// ============================================================================
interface ram_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  // master: the requesters together with the RAM array
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    input  ram_addr, ram_in, ram_load
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    output ram_addr, ram_in, ram_load
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : round-robin, burst-bounded sharing of one RAM port
// Revision 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  wire              clk,
  input  wire              reset,
  ram_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_burst_done;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_burst_done = (r_cnt >= CNT_MAX);
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // Grants are forced low during reset so no write can reach the RAM then.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = IDLE;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        case (r_owner)
          IDLE: begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
          end
          OWN0: begin
            w_gnt0 = ~w_burst_done;
            w_gnt1 = w_burst_done;
          end
          OWN1: begin
            w_gnt0 = w_burst_done;
            w_gnt1 = ~w_burst_done;
          end
          default: begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
          end
        endcase
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
    if (w_gnt0) begin
      w_owner_nxt = OWN0;
      w_last_nxt  = 1'b0;
      w_cnt_nxt   = (r_owner == OWN0) ? w_cnt_inc : CNT_ONE;
    end else if (w_gnt1) begin
      w_owner_nxt = OWN1;
      w_last_nxt  = 1'b1;
      w_cnt_nxt   = (r_owner == OWN1) ? w_cnt_inc : CNT_ONE;
    end
  end

  // Requester 0 drives the address/data mux whenever requester 1 is not granted.
  assign w_addr       = w_gnt1 ? bus.addr1  : bus.addr0;
  assign w_wdata      = w_gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.ram_addr = w_addr;
  assign bus.ram_in   = w_wdata;
  assign bus.ram_load = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
    end else begin
      bus.rvalid0 <= w_gnt0 & ~bus.we0;
      bus.rvalid1 <= w_gnt1 & ~bus.we1;
      if (w_gnt0 && !bus.we0) begin
        bus.rdata0 <= bus.ram_out;
      end
      if (w_gnt1 && !bus.we1) begin
        bus.rdata1 <= bus.ram_out;
      end
    end
  end

endmodule
`default_nettype wire
